dlx_io_mem_slave: RTL
=====================

// Module: dlx_io_mem_slave
// PURPOSE
//  Bus slave on the processor's asynchronous memory bus (AS_N/WR_N/ACK_N) that serves 32-bit word accesses.
//  Backing store is an 8-bit-wide synchronous RAM; each word moves as 4 byte transfers, big-endian.
//  Sits directly downstream of the CONTROL/MAC bus master and generates the ACK_N it consumes.
//  Adds WAIT_CYCLES programmable wait states before acknowledging.
// PARAMETERS
//  ADDR_W       10  word-address width; RAM byte address is ADDR_W+2 bits
//  WAIT_CYCLES  0   extra idle cycles between last byte transfer and ACK (0..15)
// PORTS
//  clk        in   1         system clock, all state updates on rising edge
//  reset      in   1         asynchronous, active-high; returns block to IDLE immediately
//  AS_N       in   1         address strobe from master, active-low; access request while low
//  WR_N       in   1         0 = write, 1 = read; sampled with AS_N
//  ADDR       in   ADDR_W    word address; sampled with AS_N
//  DIN        in   32        write data from master; sampled with AS_N
//  DOUT       out  32        read data to master; valid while ACK_N=0 and held until next read capture
//  ACK_N      out  1         acknowledge, active-low, exactly one-cycle pulse per completed access
//  ram_addr   out  ADDR_W+2  byte address to RAM = {ADDR_latched, byte_idx}
//  ram_wdata  out  8         byte to RAM
//  ram_we     out  1         RAM write enable, active-high
//  ram_rdata  in   8         RAM read data, 1-cycle synchronous read latency
//  STATE      out  3         FSM state encoding for debug/waveform
// BEHAVIOUR
//  Reset values: ACK_N=1, DOUT=0, ram_we=0, ram_addr=0, ram_wdata=0, STATE=IDLE(0); all outputs registered.
//  FSM: IDLE(0), WRB(1), RDB(2), RDL(3), WAIT(4), ACK(5), REL(6).
//  IDLE: AS_N=0 at edge -> latch ADDR, WR_N, DIN; byte_idx=0; go WRB if WR_N=0, else RDB.
//  Byte order: byte_idx 0 = bits[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
//  WRB: ram_we=1, ram_wdata = latched byte[byte_idx]; 4 cycles (idx 0..3), then WAIT (or ACK if WAIT_CYCLES=0).
//  RDB: ram_addr issued for idx 0..3 over 4 cycles; byte for idx k is captured into DOUT's slice k on the next edge.
//  RDL: one extra cycle to capture byte 3, then WAIT/ACK. DOUT slices update only during RDB/RDL.
//  WAIT: counts WAIT_CYCLES cycles, then ACK.
//  ACK: ACK_N=0 for exactly one cycle, then REL.
//  REL: ACK_N=1; stays until AS_N=1 sampled, then IDLE. A new access is never started without AS_N first rising.
//  Latency (edge 0 = edge sampling AS_N=0): write ACK_N low in cycle 5+WAIT_CYCLES; read in cycle 6+WAIT_CYCLES.
//  Abort: AS_N=1 sampled in WRB/RDB/RDL/WAIT -> IDLE next edge, no ACK. RAM bytes already written stay written.
//    ram_we drops the same edge.
//  ADDR/DIN/WR_N changes after the sampling edge are ignored until the next IDLE sample.
//  ram_we=0 in every state except WRB.
//  Reset mid-access: FSM to IDLE, ram_we=0 and ACK_N=1 asynchronously; any partial write is not rolled back.
//  Address wraps naturally: ram_addr is the concatenation, no overflow logic.
//  AS_N held low continuously (back-to-back without release): exactly one access is serviced; REL blocks the rest.
// TESTING
//  1 Write ADDR=3, DIN=32'hDEADBEEF, W=0 -> ram_we high 4 cycles, bytes 0x0C..0x0F = DE,AD,BE,EF; ACK_N low cycle 5 only.
//  2 Read ADDR=3 after T1 -> DOUT=32'hDEADBEEF while ACK_N low in cycle 6; DOUT unchanged after AS_N release.
//  3 WAIT_CYCLES=3, read ADDR=0 holding 32'h01020304 -> ACK_N low in cycle 9, DOUT=32'h01020304.
//  4 Write ADDR=5, DIN=32'hA1B2C3D4; AS_N=1 after 2 WRB cycles -> bytes 0x14=A1, 0x15=B2 written, 0x16/0x17 unchanged.
//     No ACK; IDLE next cycle.
//  5 Assert reset during RDB of a read -> ACK_N=1, ram_we=0, STATE=0 immediately; next AS_N access completes normally.
//  6 Hold AS_N=0 for 20 cycles on a read -> exactly one ACK_N pulse; STATE stays REL until AS_N=1.

Source files
------------

// File: rtl/dlx_io_mem_slave.sv
// dlx_io_mem_slave: asynchronous-bus (AS_N/WR_N/ACK_N) word slave in front of a
// byte-wide synchronous RAM. Each 32-bit word moves as four big-endian byte
// transfers, followed by optional wait states and a one-cycle ACK_N pulse.
module dlx_io_mem_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AS_N,
    input  logic              WR_N,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DIN,
    output logic [31:0]       DOUT,
    output logic              ACK_N,
    output logic [ADDR_W+1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WRB  = 3'd1,
        S_RDB  = 3'd2,
        S_RDL  = 3'd3,
        S_WAIT = 3'd4,
        S_ACK  = 3'd5,
        S_REL  = 3'd6
    } state_t;

    // Last value of the wait counter; with no wait states the WAIT state is skipped.
    localparam int         WAIT_LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_LAST   = WAIT_LAST_I[3:0];
    localparam state_t     POST_XFER   = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_nxt;
    logic [3:0]          r_wait_cnt;
    logic [3:0]          w_wait_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_din;
    logic [31:0]         r_dout;
    logic                r_ack_n;
    logic [ADDR_W+1:0]   r_ram_addr;
    logic [7:0]          r_ram_wdata;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   w_addr_src;
    logic [31:0]         w_din_src;

    // Big-endian byte lane: index 0 is bits [31:24].
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    get_byte = w[31:24];
            2'd1:    get_byte = w[23:16];
            2'd2:    get_byte = w[15:8];
            default: get_byte = w[7:0];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (i)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    // In IDLE the access is being accepted this edge, so the first byte must
    // come straight from the bus rather than from the not-yet-loaded latches.
    assign w_addr_src = (r_state == S_IDLE) ? ADDR : r_addr;
    assign w_din_src  = (r_state == S_IDLE) ? DIN  : r_din;

    // Next-state, byte index and wait counter; AS_N high aborts any transfer phase.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (!AS_N) begin
                    w_state_nxt = WR_N ? S_RDB : S_WRB;
                    w_idx_nxt   = 2'd0;
                end
            end
            S_WRB: begin
                if (AS_N) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx == 2'd3) begin
                    w_state_nxt = POST_XFER;
                    w_wait_nxt  = 4'd0;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
            S_RDB: begin
                if (AS_N) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx == 2'd3) begin
                    w_state_nxt = S_RDL;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
            S_RDL: begin
                w_state_nxt = AS_N ? S_IDLE : POST_XFER;
                w_wait_nxt  = 4'd0;
            end
            S_WAIT: begin
                if (AS_N) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_wait_nxt = r_wait_cnt + 4'd1;
                end
            end
            S_ACK:   w_state_nxt = S_REL;
            S_REL:   if (AS_N) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus index/counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Registered bus/RAM outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_din       <= '0;
            r_ack_n     <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            if (r_state == S_IDLE && !AS_N) begin
                r_addr <= ADDR;
                r_din  <= DIN;
            end
            r_ack_n  <= (w_state_nxt != S_ACK);
            r_ram_we <= (w_state_nxt == S_WRB);
            if (w_state_nxt == S_WRB || w_state_nxt == S_RDB)
                r_ram_addr <= {w_addr_src, w_idx_nxt};
            if (w_state_nxt == S_WRB)
                r_ram_wdata <= get_byte(w_din_src, w_idx_nxt);
        end
    end

    // Read capture: RAM data lags its address by one cycle, so the byte for
    // index k arrives while index k+1 (or RDL for the last byte) is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
        end else if (r_state == S_RDB && r_idx != 2'd0) begin
            r_dout <= put_byte(r_dout, r_idx - 2'd1, ram_rdata);
        end else if (r_state == S_RDL) begin
            r_dout <= put_byte(r_dout, 2'd3, ram_rdata);
        end
    end

    assign DOUT      = r_dout;
    assign ACK_N     = r_ack_n;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign STATE     = r_state;

endmodule
